// File: rtl/cpu_step_seq_if.sv
// Instruction memory bus between the step sequencer (master) and the
// instruction memory (slave). Read data is returned one cycle after the
// read strobe.
interface cpu_step_seq_if;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_step_seq.sv
// Single-step instruction sequencer for the teaching CPU board.
// A rising edge on start walks one instruction through
// FETCH -> LOAD -> DECODE -> EXEC -> WB -> DONE and back to IDLE.
// A HALT instruction parks the sequencer until reset.
// Optional feature: define CPU_STEP_RUN_EN to let run=1 chain DONE straight
// into the next FETCH for continuous execution.
module cpu_step_seq (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic              zero,
  cpu_step_seq_if.master    mem,
  output logic [7:0]        pc,
  output logic [15:0]       ir,
  output logic              alu_en,
  output logic              rf_we,
  output logic              busy,
  output logic              done,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    DECODE,
    EXEC,
    WB,
    DONE,
    HALT
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       start_q;
  logic       start_edge;
  logic [3:0] op;
  logic       is_alu;
  logic       is_jmp;
  logic       is_bz;
  logic       is_halt;
  logic       take_branch;

  assign start_edge  = start & ~start_q;
  assign op          = ir[15:12];
  assign is_alu      = (op >= 4'h1) && (op <= 4'hB);
  assign is_jmp      = (op == 4'hC);
  assign is_bz       = (op == 4'hD);
  assign is_halt     = (op == 4'hF);
  assign take_branch = is_jmp | (is_bz & zero);

  // The memory address always follows the program counter; only the strobe
  // distinguishes a real fetch.
  assign mem.mem_addr = pc;

`ifndef CPU_STEP_RUN_EN
  logic run_unused;
  assign run_unused = run;
`endif

  // Sample start every cycle so edges are seen only against the prior cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-state strobes; edges outside IDLE are dropped.
  always_comb begin
    state_next = state;
    mem.mem_rd = 1'b0;
    alu_en     = 1'b0;
    rf_we      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    halted     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_edge) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        mem.mem_rd = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        state_next = DECODE;
      end
      DECODE: begin
        state_next = is_halt ? HALT : EXEC;
      end
      EXEC: begin
        alu_en     = is_alu;
        state_next = WB;
      end
      WB: begin
        rf_we      = is_alu;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
`ifdef CPU_STEP_RUN_EN
        state_next = run ? FETCH : IDLE;
`else
        state_next = IDLE;
`endif
      end
      HALT: begin
        busy       = 1'b0;
        halted     = 1'b1;
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Instruction capture, sequential pc advance and jump/branch target load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 8'h00;
      ir <= 16'h0000;
    end else begin
      if (state == LOAD) begin
        ir <= mem.mem_rdata;
        pc <= pc + 8'd1;
      end else if ((state == EXEC) && take_branch) begin
        pc <= ir[7:0];
      end
    end
  end

endmodule

// File: tb/tb_cpu_step_seq.sv
// Scoreboard testbench for cpu_step_seq: stimulus pushes the expected outcome
// of each step, a monitor pops and checks when done or halted appears.
module tb_cpu_step_seq;

  typedef struct {
    logic [15:0] ir;
    logic [7:0]  fetch_pc;
    logic [7:0]  load_pc;
    logic [7:0]  pc;
    logic        alu;
    logic        halt;
    int          edge_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        run;
  logic        zero;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        alu_en;
  logic        rf_we;
  logic        busy;
  logic        done;
  logic        halted;

  logic [15:0] mem [256];
  logic [7:0]  model_pc;
  exp_t        exp_q[$];
  int          cyc;
  int          checks;
  int          failures;
  int          done_count;

  cpu_step_seq_if bus ();

  cpu_step_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .run    (run),
    .zero   (zero),
    .mem    (bus.master),
    .pc     (pc),
    .ir     (ir),
    .alu_en (alu_en),
    .rf_we  (rf_we),
    .busy   (busy),
    .done   (done),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with one cycle read latency.
  initial bus.mem_rdata = 16'h0000;
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference behaviour of one instruction step.
  function automatic exp_t model_step(input logic [7:0] cur_pc, input logic [15:0] instr,
                                      input logic z, input int k);
    exp_t r;
    int   op;
    op         = int'(instr[15:12]);
    r.ir       = instr;
    r.fetch_pc = cur_pc;
    r.load_pc  = cur_pc + 8'd1;
    r.pc       = r.load_pc;
    r.alu      = (op >= 1) && (op <= 11);
    r.halt     = (op == 15);
    if (op == 12 || (op == 13 && z)) r.pc = instr[7:0];
    r.edge_cyc = k;
    return r;
  endfunction

  // Monitor: collects per-step activity and scores it when done/halted shows.
  int          n_rd, rd_cyc, n_alu, alu_cyc, n_we, we_cyc;
  logic [7:0]  fetch_addr, snap_pc;
  logic [15:0] snap_ir;
  logic        prev_halted;
  initial begin
    done_count  = 0;
    prev_halted = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      n_rd = 0; n_alu = 0; n_we = 0;
      prev_halted = 1'b0;
    end else begin
      if (bus.mem_rd) begin n_rd++; rd_cyc = cyc; fetch_addr = bus.mem_addr; end
      if (alu_en) begin n_alu++; alu_cyc = cyc; end
      if (rf_we) begin n_we++; we_cyc = cyc; end
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (cyc == e.edge_cyc + 3) begin snap_pc = pc; snap_ir = ir; end
      end
      if (done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_latency", cyc - e.edge_cyc, 6);
          checkOutput("fetch_count", n_rd, 1);
          checkOutput("fetch_cycle", rd_cyc - e.edge_cyc, 1);
          checkOutput("fetch_addr", fetch_addr, e.fetch_pc);
          checkOutput("load_ir", snap_ir, e.ir);
          checkOutput("load_pc", snap_pc, e.load_pc);
          checkOutput("alu_en_count", n_alu, e.alu);
          checkOutput("rf_we_count", n_we, e.alu);
          if (e.alu) begin
            checkOutput("alu_en_cycle", alu_cyc - e.edge_cyc, 4);
            checkOutput("rf_we_cycle", we_cyc - e.edge_cyc, 5);
          end
          checkOutput("final_pc", pc, e.pc);
          checkOutput("final_ir", ir, e.ir);
          checkOutput("busy_in_done", busy, 1);
          checkOutput("halted_at_done", halted, e.halt);
        end
        n_rd = 0; n_alu = 0; n_we = 0;
      end
      if (halted && !prev_halted) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_halt", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("halt_latency", cyc - e.edge_cyc, 4);
          checkOutput("halt_expected", halted, e.halt);
          checkOutput("halt_pc", pc, e.load_pc);
          checkOutput("halt_ir", ir, e.ir);
          checkOutput("halt_busy", busy, 0);
          checkOutput("halt_done", done, 0);
          checkOutput("halt_alu_en_count", n_alu, e.alu);
          checkOutput("halt_rf_we_count", n_we, e.alu);
        end
        n_rd = 0; n_alu = 0; n_we = 0;
      end
      prev_halted = halted;
    end
  end

  task automatic waitStep(input int limit);
    int t;
    t = 0;
    while (!(done || halted) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) begin
      checkOutput("step_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  // Issue one single-step of instr at the model pc, optionally with an extra
  // start edge during EXEC that must be ignored.
  task automatic applyStimulus(input logic [15:0] instr, input logic z, input bit glitch);
    exp_t e;
    mem[model_pc] = instr;
    zero = z;
    @(negedge clk);
    e = model_step(model_pc, instr, z, cyc);
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (glitch) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitStep(20);
    model_pc = e.pc;
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst = 1'b0;
    start = 1'b0;
    run = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_ir", ir, 16'h0000);
    checkOutput("rst_mem_addr", bus.mem_addr, 8'h00);
    checkOutput("rst_strobes", {bus.mem_rd, alu_en, rf_we, busy, done, halted}, 6'b0);
    @(negedge clk);
    rst = 1'b1;
    model_pc = 8'h00;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    v = 16'($urandom());
    v[15:12] = 4'($urandom_range(0, 14));
    return v;
  endfunction

  initial begin
    int k;
    exp_t e;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    start = 1'b0;
    run = 1'b0;
    zero = 1'b0;
    model_pc = 8'h00;
    resetDut();

    // Directed opening steps: ALU, JMP, wrap of pc, BZ taken and not taken.
    applyStimulus(16'h1234, 1'b0, 1'b0);
    applyStimulus(16'hC0F0, 1'b0, 1'b0);
    checkOutput("jmp_pc", pc, 8'hF0);
    applyStimulus(16'hC0FF, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("wrap_pc", pc, 8'h00);
    applyStimulus(16'hD020, 1'b1, 1'b0);
    checkOutput("bz_taken_pc", pc, 8'h20);
    applyStimulus(16'hD020, 1'b0, 1'b0);
    checkOutput("bz_not_taken_pc", pc, 8'h21);
    applyStimulus(16'hE0AA, 1'b0, 1'b0);

    // Randomised steps; without the run feature run must have no effect.
    for (int i = 0; i < 30; i++) begin
`ifndef CPU_STEP_RUN_EN
      run = 1'($urandom_range(0, 1));
`endif
      applyStimulus(rand_instr(), 1'($urandom_range(0, 1)), 1'b0);
    end
    run = 1'b0;

    // Start edge during EXEC must not queue another step.
    applyStimulus(16'h5A5A, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("glitch_no_extra_busy", busy, 0);

    // Reset while in WB clears everything immediately.
    mem[model_pc] = 16'h3111;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rf_we_in_wb", rf_we, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("wb_rst_pc", pc, 8'h00);
    checkOutput("wb_rst_ir", ir, 16'h0000);
    checkOutput("wb_rst_mem_addr", bus.mem_addr, 8'h00);
    checkOutput("wb_rst_strobes", {bus.mem_rd, alu_en, rf_we, busy, done, halted}, 6'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_pc = 8'h00;
    applyStimulus(16'h7777, 1'b0, 1'b0);

    // HALT parks the sequencer and ignores further start edges.
    applyStimulus(16'hF000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("halt_ignores_start_busy", busy, 0);
      checkOutput("halt_holds", halted, 1);
    end

    // Reset with start held high: release counts as a start edge.
    rst = 1'b0;
    start = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("rst_clears_halted", halted, 0);
    mem[0] = 16'h2345;
    zero = 1'b0;
    @(negedge clk);
    e = model_step(8'h00, 16'h2345, 1'b0, cyc);
    exp_q.push_back(e);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitStep(20);
    checkOutput("held_start_pc", pc, 8'h01);
    @(negedge clk);

`ifdef CPU_STEP_RUN_EN
    // Continuous run through three ALU instructions.
    resetDut();
    for (int i = 0; i < 3; i++) begin
      mem[i] = {4'($urandom_range(1, 11)), 12'($urandom())};
    end
    @(negedge clk);
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_step(8'(i), mem[i], 1'b0, k + 6 * i));
    end
    done_count = 0;
    run = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 40 && done_count < 2; t++) @(negedge clk);
    run = 1'b0;
    for (int t = 0; t < 40 && done_count < 3; t++) @(negedge clk);
    checkOutput("run_done_count", done_count, 3);
    checkOutput("run_final_pc", pc, 8'h03);
    repeat (8) @(negedge clk);
    checkOutput("run_stops_busy", busy, 0);
`else
    // run=1 without the feature: exactly one instruction per start edge.
    resetDut();
    run = 1'b1;
    done_count = 0;
    k = 0;
    applyStimulus(16'h1111, 1'b0, 1'b0);
    applyStimulus(16'h2222, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("run_ignored_done_count", done_count, 2);
    checkOutput("run_ignored_pc", pc, 8'h02);
    checkOutput("run_ignored_busy", busy, 0 + k);
    run = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
